// File: rtl/bounding_box_tracker_if.sv
// rtl/bounding_box_tracker_if.sv - pixel mask stream in, published box out
interface bounding_box_tracker_if;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        data_valid_in;
    logic        mask_in;
    logic        nf_in;
    logic [11:0] box_x_out;
    logic [10:0] box_y_out;
    logic [11:0] box_xmax_out;
    logic [10:0] box_ymax_out;
    logic        box_found_out;
    logic        box_valid_out;

    modport master (
        output hcount_in, vcount_in, data_valid_in, mask_in, nf_in,
        input  box_x_out, box_y_out, box_xmax_out, box_ymax_out, box_found_out, box_valid_out
    );
    modport slave (
        input  hcount_in, vcount_in, data_valid_in, mask_in, nf_in,
        output box_x_out, box_y_out, box_xmax_out, box_ymax_out, box_found_out, box_valid_out
    );
endinterface

// File: rtl/bounding_box_tracker.sv
// rtl/bounding_box_tracker.sv - per-frame min/max extent of mask hits, published at frame end
module bounding_box_tracker #(
    parameter int H_ACTIVE    = 960,
    parameter int V_ACTIVE    = 640,
    parameter int MIN_PIXELS  = 16,
    parameter int COUNT_WIDTH = 20
) (
    input  logic clk_in,
    input  logic rst_n_in,
    bounding_box_tracker_if.slave bus
);
    typedef enum logic [1:0] {WAIT_FRAME, ACCUM, PUBLISH} state_t;

    localparam logic [10:0]            H_LIM   = 11'(H_ACTIVE);
    localparam logic [9:0]             V_LIM   = 10'(V_ACTIVE);
    localparam logic [COUNT_WIDTH-1:0] MIN_CNT = COUNT_WIDTH'(MIN_PIXELS);

    state_t state, state_next;

    logic [11:0] acc_xmin, acc_xmax, snap_xmin, snap_xmax;
    logic [10:0] acc_ymin, acc_ymax, snap_ymin, snap_ymax;
    logic [COUNT_WIDTH-1:0] acc_count, snap_count;

    logic [11:0] nx_xmin, nx_xmax;
    logic [10:0] nx_ymin, nx_ymax;
    logic [COUNT_WIDTH-1:0] nx_count;

    logic hit, collect, take_snapshot, publish;
    logic [11:0] hx;
    logic [10:0] vy;

    assign hx  = {1'b0, bus.hcount_in};
    assign vy  = {1'b0, bus.vcount_in};
    assign hit = bus.data_valid_in & bus.mask_in & (bus.hcount_in < H_LIM) & (bus.vcount_in < V_LIM);

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state <= WAIT_FRAME;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_FRAME: if (bus.nf_in) state_next = ACCUM;
            ACCUM:      if (bus.nf_in) state_next = PUBLISH;
            PUBLISH:    state_next = bus.nf_in ? PUBLISH : ACCUM;
            default:    state_next = WAIT_FRAME;
        endcase
    end

    always_comb begin
        publish       = (state == PUBLISH);
        take_snapshot = bus.nf_in && (state != WAIT_FRAME);
        collect       = hit && ((state != WAIT_FRAME) || bus.nf_in);
    end

    // nf_in restarts the accumulators; a coincident hit seeds the new frame
    always_comb begin
        nx_xmin  = acc_xmin;
        nx_xmax  = acc_xmax;
        nx_ymin  = acc_ymin;
        nx_ymax  = acc_ymax;
        nx_count = acc_count;
        if (bus.nf_in) begin
            nx_xmin  = '0;
            nx_xmax  = '0;
            nx_ymin  = '0;
            nx_ymax  = '0;
            nx_count = '0;
        end
        if (collect) begin
            if (bus.nf_in || acc_count == '0) begin
                nx_xmin  = hx;
                nx_xmax  = hx;
                nx_ymin  = vy;
                nx_ymax  = vy;
                nx_count = COUNT_WIDTH'(1);
            end else begin
                if (hx < acc_xmin) nx_xmin = hx;
                if (hx > acc_xmax) nx_xmax = hx;
                if (vy < acc_ymin) nx_ymin = vy;
                if (vy > acc_ymax) nx_ymax = vy;
                if (acc_count != '1) nx_count = acc_count + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            acc_xmin   <= '0;
            acc_xmax   <= '0;
            acc_ymin   <= '0;
            acc_ymax   <= '0;
            acc_count  <= '0;
            snap_xmin  <= '0;
            snap_xmax  <= '0;
            snap_ymin  <= '0;
            snap_ymax  <= '0;
            snap_count <= '0;
        end else begin
            acc_xmin  <= nx_xmin;
            acc_xmax  <= nx_xmax;
            acc_ymin  <= nx_ymin;
            acc_ymax  <= nx_ymax;
            acc_count <= nx_count;
            if (take_snapshot) begin
                snap_xmin  <= acc_xmin;
                snap_xmax  <= acc_xmax;
                snap_ymin  <= acc_ymin;
                snap_ymax  <= acc_ymax;
                snap_count <= acc_count;
            end
        end
    end

    // Too few hits: keep the last good box so the display does not jump
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            bus.box_x_out     <= '0;
            bus.box_y_out     <= '0;
            bus.box_xmax_out  <= '0;
            bus.box_ymax_out  <= '0;
            bus.box_found_out <= 1'b0;
            bus.box_valid_out <= 1'b0;
        end else begin
            bus.box_valid_out <= publish;
            if (publish) begin
                if (snap_count >= MIN_CNT) begin
                    bus.box_x_out     <= snap_xmin;
                    bus.box_y_out     <= snap_ymin;
                    bus.box_xmax_out  <= snap_xmax;
                    bus.box_ymax_out  <= snap_ymax;
                    bus.box_found_out <= 1'b1;
                end else begin
                    bus.box_found_out <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_bounding_box_tracker.sv
// tb/tb_bounding_box_tracker.sv - scoreboard bench for bounding_box_tracker
module tb_bounding_box_tracker;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bounding_box_tracker_if bif ();

    bounding_box_tracker dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bif.slave)
    );

    typedef struct packed {
        logic [11:0] x;
        logic [10:0] y;
        logic [11:0] xm;
        logic [10:0] ym;
        logic        found;
    } box_t;

    box_t exp_q[$];
    int vectors = 0;
    int errors  = 0;

    function automatic box_t mk(int x, int y, int xm, int ym, int f);
        box_t b;
        b.x = 12'(x); b.y = 11'(y); b.xm = 12'(xm); b.ym = 11'(ym); b.found = 1'(f);
        return b;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bif.box_valid_out === 1'b1) begin
            box_t act, exp;
            act = {bif.box_x_out, bif.box_y_out, bif.box_xmax_out, bif.box_ymax_out, bif.box_found_out};
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got box=(%0d,%0d,%0d,%0d) found=%0d, expected no pulse",
                         act.x, act.y, act.xm, act.ym, act.found);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL box_publish: got (%0d,%0d,%0d,%0d) found=%0d, expected (%0d,%0d,%0d,%0d) found=%0d",
                             act.x, act.y, act.xm, act.ym, act.found, exp.x, exp.y, exp.xm, exp.ym, exp.found);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bif.data_valid_in = 1'b0;
        bif.mask_in       = 1'b0;
        bif.nf_in         = 1'b0;
        bif.hcount_in     = '0;
        bif.vcount_in     = '0;
    endtask

    task automatic pix(input int h, input int v, input bit m, input bit dv, input int n);
        for (int i = 0; i < n; i++) begin
            bif.hcount_in     = 11'(h);
            bif.vcount_in     = 10'(v);
            bif.mask_in       = m;
            bif.data_valid_in = dv;
            tick();
        end
        idle();
    endtask

    task automatic frame_end(input bit with_hit, input int h, input int v);
        idle();
        bif.nf_in = 1'b1;
        if (with_hit) begin
            bif.hcount_in     = 11'(h);
            bif.vcount_in     = 10'(v);
            bif.mask_in       = 1'b1;
            bif.data_valid_in = 1'b1;
        end
        tick();
        idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        vectors++;
        if ({bif.box_x_out, bif.box_y_out, bif.box_xmax_out, bif.box_ymax_out,
             bif.box_found_out, bif.box_valid_out} !== '0) begin
            errors++;
            $display("FAIL %s: got box=(%0d,%0d,%0d,%0d) found=%0d valid=%0d, expected all zero", tag,
                     bif.box_x_out, bif.box_y_out, bif.box_xmax_out, bif.box_ymax_out,
                     bif.box_found_out, bif.box_valid_out);
        end
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        repeat (3) tick();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset_state");
        tick();
        rst_n = 1'b1;
        tick();

        // hits before the first nf are ignored; first nf publishes nothing
        pix(1, 1, 1, 1, 20);
        frame_end(0, 0, 0);
        repeat (3) tick();

        // 20 hits spanning (100,50)..(149,89)
        pix(100, 50, 1, 1, 1);
        for (int i = 0; i < 18; i++) pix(120, 60 + i, 1, 1, 1);
        pix(149, 89, 1, 1, 1);
        exp_q.push_back(mk(100, 50, 149, 89, 1));
        frame_end(0, 0, 0);
        drain();

        // 15 hits: below threshold, box holds
        pix(500, 300, 1, 1, 15);
        exp_q.push_back(mk(100, 50, 149, 89, 0));
        frame_end(0, 0, 0);
        drain();

        // out-of-area and invalid pixels, then exactly 16 hits at the corner
        pix(960, 10, 1, 1, 4);
        pix(10, 640, 1, 1, 4);
        pix(0, 0, 1, 0, 4);
        pix(0, 0, 0, 1, 4);
        pix(959, 639, 1, 1, 16);
        exp_q.push_back(mk(959, 639, 959, 639, 1));
        frame_end(0, 0, 0);
        drain();

        // nf coincident with hit: closes an empty frame, hit seeds the next
        exp_q.push_back(mk(959, 639, 959, 639, 0));
        frame_end(1, 5, 5);
        pix(10, 10, 1, 1, 15);
        exp_q.push_back(mk(5, 5, 10, 10, 1));
        frame_end(0, 0, 0);
        drain();

        // back-to-back nf: second lands in PUBLISH and closes an empty frame
        pix(200, 100, 1, 1, 16);
        exp_q.push_back(mk(200, 100, 200, 100, 1));
        exp_q.push_back(mk(200, 100, 200, 100, 0));
        frame_end(0, 0, 0);
        frame_end(0, 0, 0);
        drain();

        // reset mid-frame discards partial frame and clears outputs
        pix(300, 300, 1, 1, 30);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midframe_reset");
        tick();
        rst_n = 1'b1;
        tick();
        frame_end(0, 0, 0);
        repeat (3) tick();
        pix(7, 8, 1, 1, 16);
        pix(9, 12, 1, 1, 1);
        exp_q.push_back(mk(7, 8, 9, 12, 1));
        frame_end(0, 0, 0);
        drain();

        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_valid: %0d expected publishes never seen, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
